// File: rtl/defines.sv
// Shared pipeline defines: widths, the NOP instruction, the zero PC and the
// pipeline stall codes (same encoding as the fetch stage).
`ifndef IF_ID_DEFINES_SV
`define IF_ID_DEFINES_SV

`define MEM_ADDR_WIDTH 32
`define REG_DATA_WIDTH 32
`define INST_NOP       32'h00000013
`define PC_ZERO        32'h00000000

`define STALL_WIDTH    2
`define STALL_NONE     2'd0
`define STALL_LOAD     2'd1
`define STALL_BRANCH   2'd2

`endif

// File: rtl/if_id_buf.sv
// if_id_buf: two-entry buffer between the fetch and decode stages.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears all state while low
//   stall      pipeline stall code (LOAD holds decode, BRANCH inserts a bubble)
//   flush      redirect: drop every buffered entry and the same-cycle fetch
//   if_valid   fetch presents if_pc/if_inst
//   if_pc      PC of the presented instruction
//   if_inst    presented instruction word
//   if_ready   buffer accepts a push this cycle (state-only, combinational)
//   id_valid   id_pc/id_inst carry a real instruction for decode
//   id_pc      PC of the head entry
//   id_inst    head instruction, NOP when id_valid is low
//   occupancy  number of valid entries; equals the FSM state encoding
//
// Handshake: a push happens on a rising edge when if_valid & if_ready & ~flush;
// a pop happens when id_valid & ~hold & ~flush. Pushed data reaches id_* only
// from the following cycle (no bypass).
`ifndef IF_ID_DEFINES_SV
`include "defines.sv"
`endif

module if_id_buf #(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`STALL_WIDTH-1:0]     stall,
  input  logic                        flush,
  input  logic                        if_valid,
  input  logic [`MEM_ADDR_WIDTH-1:0]  if_pc,
  input  logic [`REG_DATA_WIDTH-1:0]  if_inst,
  output logic                        if_ready,
  output logic                        id_valid,
  output logic [`MEM_ADDR_WIDTH-1:0]  id_pc,
  output logic [`REG_DATA_WIDTH-1:0]  id_inst,
  output logic [1:0]                  occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [1:0] FULL_OCC = 2'(DEPTH);

  state_t                       state_q, state_d;
  logic                         head_q, head_d;
  logic [`MEM_ADDR_WIDTH-1:0]   entry_pc   [2];
  logic [`REG_DATA_WIDTH-1:0]   entry_inst [2];

  logic hold;
  logic bubble;
  logic push;
  logic pop;
  logic wr_idx;

  assign occupancy = state_q;
  assign if_ready  = (state_q != FULL_OCC);

  assign bubble = (stall == `STALL_BRANCH);
  assign hold   = (stall == `STALL_LOAD) | bubble;

  assign id_valid = (state_q != EMPTY) & ~bubble;
  assign id_pc    = (state_q != EMPTY) ? entry_pc[head_q] : `PC_ZERO;
  assign id_inst  = id_valid ? entry_inst[head_q] : `INST_NOP;

  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & ~hold & ~flush;

  // Slot behind the current head; only meaningful in EMPTY/ONE, which are
  // the only states where a push is possible.
  assign wr_idx = head_q ^ (state_q == ONE);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) state_d = ONE;
        end
        ONE: begin
          if (pop) head_d = ~head_q;
          if (push && !pop)      state_d = TWO;
          else if (pop && !push) state_d = EMPTY;
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = ~head_q;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= EMPTY;
      head_q        <= 1'b0;
      entry_pc[0]   <= `PC_ZERO;
      entry_pc[1]   <= `PC_ZERO;
      entry_inst[0] <= `INST_NOP;
      entry_inst[1] <= `INST_NOP;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      if (push) begin
        entry_pc[wr_idx]   <= if_pc;
        entry_inst[wr_idx] <= if_inst;
      end
    end
  end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered fetch entries; only DEPTH=2 is supported.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-low reset; all state cleared while low.
REQ-005 stall  in  `STALL_WIDTH  pipeline stall code, same encoding as the fetch stage.
REQ-006 flush  in  1  branch/jump redirect; discard all buffered instructions.
REQ-007 if_valid  in  1  fetch stage presents a valid pc/inst pair this cycle.
REQ-008 if_pc  in  `MEM_ADDR_WIDTH  PC of the presented instruction.
REQ-009 if_inst  in  `REG_DATA_WIDTH  presented instruction word.
REQ-010 if_ready  out  1  buffer can accept a push this cycle.
REQ-011 id_valid  out  1  id_pc/id_inst hold a real instruction for decode.
REQ-012 id_pc  out  `MEM_ADDR_WIDTH  PC of the head entry.
REQ-013 id_inst  out  `REG_DATA_WIDTH  head instruction; `INST_NOP when id_valid=0.
REQ-014 occupancy  out  2  number of valid entries, 0..2.

Function
REQ-015 State machine SHALL have states EMPTY, ONE and TWO, encoded as occupancy 0, 1 and 2.
REQ-016 push = if_valid & if_ready & ~flush.
REQ-017 hold = (stall == `STALL_LOAD) | (stall == `STALL_BRANCH).
REQ-018 pop = id_valid & ~hold & ~flush.
REQ-019 if_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO; it is combinational from state only.
REQ-020 Transitions: EMPTY+push->ONE; ONE+push&~pop->TWO; ONE+pop&~push->EMPTY; ONE+push&pop->ONE with the new entry at head; TWO+pop->ONE; otherwise hold state.
REQ-021 Entries SHALL leave in push order; the head entry drives id_pc and id_inst combinationally with zero-cycle latency from the register.
REQ-022 A pushed instruction SHALL be visible on id_* no earlier than the cycle after the push (1-cycle latency, no bypass).
REQ-023 stall == `STALL_LOAD: id_valid, id_pc and id_inst SHALL stay stable; no pop; push is still allowed while not full.
REQ-024 stall == `STALL_BRANCH: id_valid SHALL be 0 and id_inst SHALL be `INST_NOP (bubble); buffered entries are retained and no pop occurs.
REQ-025 flush SHALL take priority over push, pop and stall; the next state is EMPTY, and the same-cycle if_valid is dropped.
REQ-026 Push in TWO SHALL be ignored: the entry is not written and the state does not change.
REQ-027 Storage SHALL be two entry registers with a 1-bit head pointer that wraps 1->0; write index = head + occupancy mod 2.

Reset
REQ-028 While rst=0: state EMPTY, occupancy 0, head pointer 0, id_valid 0, id_pc `PC_ZERO, id_inst `INST_NOP, if_ready 1.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously), without waiting for a clock edge.
REQ-030 After rst is released, the first push is accepted on the first rising edge.

Structure
REQ-031 `INST_NOP (32'h00000013), `PC_ZERO and the stall codes SHALL live in the shared defines.sv; the FSM state typedef SHALL be local to the module.
REQ-032 The block SHALL be a single module with no sub-modules; the 2-entry storage is inline.

Verification
REQ-033 Reset release, then push pc=0x0 inst=0x00100093 -> next cycle id_valid=1, id_pc=0x0, id_inst=0x00100093, occupancy=1.
REQ-034 Two pushes (0x4, 0x8) with stall=`STALL_LOAD -> occupancy=2, if_ready=0, id_pc=0x4 held; stall released -> id_pc=0x8 after one cycle.
REQ-035 occupancy=2 and flush=1 with if_valid=1 -> next cycle occupancy=0, id_valid=0, id_inst=0x00000013.
REQ-036 occupancy=1 and stall=`STALL_BRANCH -> id_valid=0, id_inst=`INST_NOP, occupancy still 1; stall cleared -> the original entry reappears.
REQ-037 occupancy=1 with simultaneous push(0xC) and pop -> occupancy stays 1, id_pc=0xC next cycle.
REQ-038 rst pulled low mid-cycle with occupancy=2 -> id_valid=0 and if_ready=1 before the next clock edge.
